// File: rtl/scan_chain_loader.sv
// Scan-chain configuration loader: accepts config words over valid/ready and shifts them
// LSB-first into the scan chain, asserting scan_en for exactly CHAIN_LEN cycles per load.
module scan_chain_loader #(
    parameter int unsigned CHAIN_LEN = 64,
    parameter int unsigned WORD_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              scan_en,
    output logic              scan_in,
    output logic              busy,
    output logic              done
);

    localparam int unsigned NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int unsigned LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
    localparam int unsigned BCW       = $clog2(WORD_W + 1);
    localparam int unsigned WCW       = $clog2(NWORDS + 1);

    typedef enum logic [1:0] {StIdle, StWaitWord, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [WCW-1:0]    word_cnt_q, word_cnt_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [BCW-1:0]    nbits_q, nbits_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              scan_en_q, scan_en_d;
    logic              scan_in_q, scan_in_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;
    logic              last_word;

    // A word offered in the same cycle as abort must not look accepted to the host.
    assign cfg_ready = cfg_ready_q & ~abort;
    assign scan_en   = scan_en_q;
    assign scan_in   = scan_in_q;
    assign busy      = busy_q;
    assign done      = done_q;

    assign accept    = (state_q == StWaitWord) && cfg_ready_q && cfg_valid && !abort;
    assign last_word = (word_cnt_q == WCW'(NWORDS - 1));

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        nbits_d    = nbits_q;
        shreg_d    = shreg_q;
        scan_in_d  = scan_in_q;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d    = StWaitWord;
                    word_cnt_d = '0;
                end
            end
            StWaitWord: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (accept) begin
                    state_d   = StShift;
                    scan_in_d = cfg_data[0];
                    shreg_d   = cfg_data >> 1;
                    bit_cnt_d = '0;
                    nbits_d   = last_word ? BCW'(LAST_BITS) : BCW'(WORD_W);
                end
            end
            StShift: begin
                // bit_cnt_q is the index of the bit currently presented on scan_in.
                if (abort) begin
                    state_d = StIdle;
                end else if (bit_cnt_q == nbits_q - BCW'(1)) begin
                    if (last_word) begin
                        state_d = StDone;
                    end else begin
                        state_d    = StWaitWord;
                        word_cnt_d = word_cnt_q + WCW'(1);
                    end
                end else begin
                    scan_in_d = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_d != StShift) begin
            scan_in_d = 1'b0;
        end
        cfg_ready_d = (state_d == StWaitWord);
        scan_en_d   = (state_d == StShift);
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            word_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            nbits_q     <= '0;
            shreg_q     <= '0;
            cfg_ready_q <= 1'b0;
            scan_en_q   <= 1'b0;
            scan_in_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            nbits_q     <= nbits_d;
            shreg_q     <= shreg_d;
            cfg_ready_q <= cfg_ready_d;
            scan_en_q   <= scan_en_d;
            scan_in_q   <= scan_in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_scan_chain_loader.sv
// Bench for scan_chain_loader: a 20-stage/8-bit loader and a 16-stage/16-bit loader, each
// feeding a behavioural scan chain that captures on the falling edge.
module tb_scan_chain_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        abort = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_data = '0;

    logic ready_a, sen_a, sin_a, busy_a, done_a;
    logic ready_b, sen_b, sin_b, busy_b, done_b;

    scan_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort),
        .cfg_data(cfg_data[7:0]), .cfg_valid(cfg_valid), .cfg_ready(ready_a),
        .scan_en(sen_a), .scan_in(sin_a), .busy(busy_a), .done(done_a)
    );

    scan_chain_loader #(.CHAIN_LEN(16), .WORD_W(16)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(ready_b),
        .scan_en(sen_b), .scan_in(sin_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    // Scan chains: stage0 takes si, every stage passes to the next on the falling edge.
    logic [19:0] chain_a = '0;
    logic [15:0] chain_b = '0;
    int sen_cnt_a = 0, done_cnt_a = 0, sen_cnt_b = 0, done_cnt_b = 0;

    always @(negedge clk) begin
        if (sen_a) begin
            chain_a   <= {chain_a[18:0], sin_a};
            sen_cnt_a <= sen_cnt_a + 1;
        end
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (sen_b) begin
            chain_b   <= {chain_b[14:0], sin_b};
            sen_cnt_b <= sen_cnt_b + 1;
        end
        if (done_b) done_cnt_b <= done_cnt_b + 1;
    end

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Bit stream is word0 LSB first; bit k of the stream ends in stage 19-k.
    function automatic logic [19:0] exp_chain_a(input logic [7:0] w0, w1, w2);
        logic [23:0] s;
        logic [19:0] r;
        s = {w2, w1, w0};
        for (int k = 0; k < 20; k++) r[19-k] = s[k];
        return r;
    endfunction

    function automatic logic [15:0] exp_chain_b(input logic [15:0] w);
        logic [15:0] r;
        for (int k = 0; k < 16; k++) r[15-k] = w[k];
        return r;
    endfunction

    task automatic load_a(input logic [7:0] w0, w1, w2, input int s0, s1, s2, input bit poke);
        logic [7:0] w[3];
        int s[3];
        int base_sen, base_done, guard;
        w[0] = w0; w[1] = w1; w[2] = w2;
        s[0] = s0; s[1] = s1; s[2] = s2;
        base_sen  = sen_cnt_a;
        base_done = done_cnt_a;
        start_a = 1'b1;
        cyc = 1;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            guard = 0;
            while (!ready_a && guard < 200) begin
                if (poke && i == 1 && guard == 0) start_a = 1'b1;
                step();
                start_a = 1'b0;
                guard++;
            end
            check("a_ready_timeout", 32'(guard < 200), 32'd1);
            for (int j = 0; j < s[i]; j++) begin
                step();
                check("a_gap_scan_en", 32'(sen_a), 32'd0);
            end
            cfg_data  = {8'h00, w[i]};
            cfg_valid = 1'b1;
            step();
            cfg_valid = 1'b0;
        end
        guard = 0;
        while (!done_a && guard < 200) begin
            step();
            guard++;
        end
        check("a_latency", 32'(cyc), 32'(25 + s0 + s1 + s2));
        check("a_busy_at_done", 32'(busy_a), 32'd1);
        step();
        check("a_done_one_cycle", 32'(done_a), 32'd0);
        check("a_busy_after_done", 32'(busy_a), 32'd0);
        check("a_scan_en_cycles", 32'(sen_cnt_a - base_sen), 32'd20);
        check("a_done_count", 32'(done_cnt_a - base_done), 32'd1);
        check("a_chain", 32'(chain_a), 32'(exp_chain_a(w0, w1, w2)));
    endtask

    task automatic load_b(input logic [15:0] w);
        int base_sen, base_done, guard;
        base_sen  = sen_cnt_b;
        base_done = done_cnt_b;
        start_b = 1'b1;
        cyc = 1;
        step();
        start_b = 1'b0;
        check("b_ready", 32'(ready_b), 32'd1);
        cfg_data  = w;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        guard = 0;
        while (!done_b && guard < 200) begin
            step();
            guard++;
        end
        check("b_latency", 32'(cyc), 32'd19);
        check("b_busy_at_done", 32'(busy_b), 32'd1);
        step();
        check("b_done_one_cycle", 32'(done_b), 32'd0);
        check("b_busy_after_done", 32'(busy_b), 32'd0);
        check("b_scan_en_cycles", 32'(sen_cnt_b - base_sen), 32'd16);
        check("b_done_count", 32'(done_cnt_b - base_done), 32'd1);
        check("b_chain", 32'(chain_b), 32'(exp_chain_b(w)));
    endtask

    initial begin
        int base_done;
        int guard;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("reset_a_outputs", 32'({ready_a, sen_a, sin_a, busy_a, done_a}), 32'd0);
        check("reset_b_outputs", 32'({ready_b, sen_b, sin_b, busy_b, done_b}), 32'd0);
        reset_n = 1'b1;
        step();

        // Back-to-back load, then the same load with a 5-cycle gap before word 1
        load_a(8'hA5, 8'h3C, 8'hF9, 0, 0, 0, 1'b0);
        check("a_stage19", 32'(chain_a[19]), 32'd1);
        load_a(8'hA5, 8'h3C, 8'hF9, 0, 5, 0, 1'b0);

        // Abort at the 4th shift of word 1
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        cfg_data  = 16'h00A5;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        guard = 0;
        while (!ready_a && guard < 200) begin
            step();
            guard++;
        end
        cfg_data  = 16'h003C;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        repeat (3) step();
        check("abort_in_shift", 32'(sen_a), 32'd1);
        base_done = done_cnt_a;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_outputs", 32'({ready_a, sen_a, busy_a, done_a}), 32'd0);
        repeat (30) step();
        check("abort_no_done", 32'(done_cnt_a - base_done), 32'd0);
        check("abort_stays_idle", 32'(busy_a), 32'd0);

        // Abort in WAIT_WORD with a word offered: masked ready, word dropped
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        cfg_data  = 16'h00FF;
        cfg_valid = 1'b1;
        abort     = 1'b1;
        #1;
        check("abort_masks_ready", 32'(ready_a), 32'd0);
        step();
        abort     = 1'b0;
        cfg_valid = 1'b0;
        check("abort_wait_outputs", 32'({ready_a, sen_a, busy_a}), 32'd0);
        repeat (3) step();
        check("abort_wait_no_shift", 32'(sen_a), 32'd0);
        load_a(8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0, 1'b0);

        // start+abort together in IDLE, then start pulsed while busy
        start_a = 1'b1;
        abort   = 1'b1;
        step();
        start_a = 1'b0;
        abort   = 1'b0;
        check("start_abort_idle", 32'({busy_a, ready_a}), 32'd0);
        step();
        check("start_abort_idle2", 32'(busy_a), 32'd0);
        load_a(8'h5A, 8'hC3, 8'h96, 1, 0, 2, 1'b1);

        // Asynchronous reset mid-SHIFT
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        cfg_data  = 16'h00FF;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        step();
        check("pre_reset_shifting", 32'(sen_a), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({ready_a, sen_a, sin_a, busy_a, done_a}), 32'd0);
        #3 reset_n = 1'b1;
        step();
        check("post_reset_idle", 32'(busy_a), 32'd0);
        load_a(8'h0F, 8'hE1, 8'h7B, 0, 0, 0, 1'b0);

        // Randomized loads with random valid stalls
        for (int r = 0; r < 4; r++) begin
            load_a(8'($urandom), 8'($urandom), 8'($urandom),
                   int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                   int'($urandom_range(3, 0)), 1'b0);
        end

        // Single exact word
        load_b(16'h8001);
        check("b_stage15", 32'(chain_b[15]), 32'd1);
        check("b_stage0", 32'(chain_b[0]), 32'd1);
        load_b(16'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
